pos_sweep_eval: RTL and testbench
=================================

# pos_sweep_eval

Programmable product-of-sums evaluator with a built-in exhaustive input sweeper. It generalises the fixed 5-input POS function blocks to N_IN inputs and N_CLAUSE run-time-loadable clauses. On `start` it walks every input vector from 0 to 2^N_IN-1 and records the truth table and the minterm count. It sits beside the logic-exercise benches as a self-checking function engine, and software or a bench reads back `tt`/`ones_cnt` after `done`.

## Interface
- N_IN, 5, number of function inputs (2..8)
- N_CLAUSE, 3, number of OR-clauses ANDed together (1..8)

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  write clause `cfg_idx`; ignored while `busy`
- cfg_idx  in  max(1,$clog2(N_CLAUSE))  clause index; values >= N_CLAUSE ignored
- cfg_pos  in  N_IN  bit i set: clause contains literal x[i]
- cfg_neg  in  N_IN  bit i set: clause contains literal ~x[i]
- start  in  1  begin sweep; sampled only in IDLE
- step  in  1  advance enable; present only with POS_SWEEP_STEP_EN
- busy  out  1  high in SWEEP
- done  out  1  one-cycle pulse after the last vector
- vec  out  N_IN  vector evaluated in the current SWEEP cycle
- f  out  1  registered F of the last evaluated vector
- ones_cnt  out  N_IN+1  number of vectors with F=1
- tt  out  2^N_IN  truth table, bit k = F(vec=k)

## Operation
- Clause c = OR over i of (pos[c][i] & x[i]) | (neg[c][i] & ~x[i]). An empty clause (pos=neg=0) evaluates to 1 and is effectively disabled. F = AND of all clauses.
- A literal with both pos and neg set makes the clause constant 1.
- Clause RAM is N_CLAUSE×2N_IN flops and is cleared to 0 by reset, so F=1 after reset.
- FSM: IDLE → SWEEP on `start`. SWEEP → DONE after vector 2^N_IN-1 is evaluated. DONE → IDLE unconditionally.
- On IDLE→SWEEP: vec←0, tt←0, ones_cnt←0.
- Each advancing SWEEP cycle:
  - tt[vec]←F(vec)
  - f←F(vec)
  - ones_cnt←ones_cnt+F(vec)
  - vec←vec+1 (wraps to 0 after the last vector)
- `start` in SWEEP or DONE is ignored. `cfg_we` in SWEEP is ignored. `cfg_we` in IDLE or DONE updates the clause at the next edge.
- `tt`, `ones_cnt` and `f` hold their values in IDLE until the next `start`.
- `ones_cnt` never overflows: its maximum is 2^N_IN, which fits N_IN+1 bits.

## Timing
- Reset values: busy=0, done=0, vec=0, f=0, ones_cnt=0, tt=0, state=IDLE, all clauses 0.
- Cycle 0: `start` sampled high in IDLE.
- Cycles 1..2^N_IN: busy=1 and vec=k-1 in cycle k (free-running mode).
- Cycle 2^N_IN+1: done=1, busy=0, and final `tt`/`ones_cnt` are valid.
- Cycle 2^N_IN+2: IDLE. A `start` asserted in the DONE cycle is ignored.
- Start-to-done latency is 2^N_IN+1 cycles (32+1 with defaults).
- Reset mid-sweep clears everything immediately and asynchronously, including the clause RAM. No `done` is produced.

## Configuration
- POS_SWEEP_STEP_EN defined:
  - Adds the `step` input.
  - In SWEEP, a vector is evaluated and recorded only in cycles with step=1. Otherwise all SWEEP state holds, `busy` stays 1 and `vec` is stable.
  - `done` follows the cycle after the step that evaluated the last vector.
- POS_SWEEP_STEP_EN undefined:
  - No `step` port.
  - Every SWEEP cycle advances, giving fixed latency 2^N_IN+1.

## Test plan
- Reset, no configuration, start → done exactly 33 cycles after start, ones_cnt=32, tt=32'hFFFF_FFFF.
- Load clause0 pos=5'b00101 neg=5'b00010, clause1 pos=5'b01000 neg=5'b00001, clause2 pos=5'b00010 neg=5'b10100, then start → ones_cnt=17, tt[0]=1, tt[1]=0, and tt bit k matches the (A+~B+C)(~A+D)(B+~C+~E) reference model with A=vec[0]..E=vec[4].
- Pulse `start` and `cfg_we` mid-sweep (cycle 10) → no restart, clause unchanged, result identical to the previous test.
- Assert rst_n=0 at cycle 15 of a sweep → all outputs 0 in the same cycle, no `done`. A new start after reconfiguration completes normally.
- Set N_IN=3, N_CLAUSE=1 with clause pos=3'b111 → done at cycle 9, ones_cnt=7, tt=8'hFE.
- With POS_SWEEP_STEP_EN, step high every 3rd cycle → vec advances only on steps, done 1 cycle after the 32nd step, ones_cnt matches the free-running run.

Source files
------------

// File: rtl/pos_sweep_eval.sv
// pos_sweep_eval
//   Programmable product-of-sums evaluator with an exhaustive input sweeper.
//   F = AND over clauses of (OR over i of pos[c][i]&x[i] | neg[c][i]&~x[i]).
//   An empty clause evaluates to 1. On start every vector 0..2^N_IN-1 is
//   evaluated once, building the truth table tt and the minterm count.
//
//   Optional feature macro: POS_SWEEP_STEP_EN
//     defined   : adds input `step`; a SWEEP cycle advances only when step=1
//     undefined : every SWEEP cycle advances (latency 2^N_IN+1)
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset (also clears clause RAM)
//   cfg_we     write clause cfg_idx (ignored while busy)
//   cfg_idx    clause index; values >= N_CLAUSE are ignored
//   cfg_pos    positive-literal mask for the clause
//   cfg_neg    negative-literal mask for the clause
//   start      begin a sweep (sampled only in IDLE)
//   step       advance enable (POS_SWEEP_STEP_EN only)
//   busy       high in SWEEP
//   done       one-cycle pulse after the last vector
//   vec        vector evaluated in the current SWEEP cycle
//   f          registered F of the last evaluated vector
//   ones_cnt   number of vectors with F=1
//   tt         truth table, bit k = F(k)

// One OR-clause. Empty clause is satisfied so unused slots drop out of the AND.
module pos_sweep_clause #(
  parameter int N_IN = 5
) (
  input  logic [N_IN-1:0] i_pos,
  input  logic [N_IN-1:0] i_neg,
  input  logic [N_IN-1:0] i_x,
  output logic            o_sat
);
  logic w_empty;
  logic w_hit;
  assign w_empty = ~(|i_pos) & ~(|i_neg);
  assign w_hit   = |((i_pos & i_x) | (i_neg & ~i_x));
  assign o_sat   = w_empty | w_hit;
endmodule

module pos_sweep_eval #(
  parameter  int N_IN     = 5,
  parameter  int N_CLAUSE = 3,
  localparam int IDX_W    = (N_CLAUSE > 1) ? $clog2(N_CLAUSE) : 1,
  localparam int NV       = 1 << N_IN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [N_IN-1:0]  cfg_pos,
  input  logic [N_IN-1:0]  cfg_neg,
  input  logic             start,
`ifdef POS_SWEEP_STEP_EN
  input  logic             step,
`endif
  output logic             busy,
  output logic             done,
  output logic [N_IN-1:0]  vec,
  output logic             f,
  output logic [N_IN:0]    ones_cnt,
  output logic [NV-1:0]    tt
);

  typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_DONE} state_t;

  state_t r_state, w_nxt;

  logic [N_CLAUSE-1:0][N_IN-1:0] r_pos;
  logic [N_CLAUSE-1:0][N_IN-1:0] r_neg;
  logic [N_CLAUSE-1:0]           w_sat;

  logic [N_IN-1:0] r_vec;
  logic            r_f;
  logic [N_IN:0]   r_ones;
  logic [NV-1:0]   r_tt;

  logic w_f;
  logic w_adv;
  logic w_last;
  logic w_go;
  logic w_cfg_ok;

  // Clause evaluators, one per clause slot, all looking at the current vector.
  for (genvar c = 0; c < N_CLAUSE; c++) begin : g_cl
    pos_sweep_clause #(.N_IN(N_IN)) u_cl (
      .i_pos (r_pos[c]),
      .i_neg (r_neg[c]),
      .i_x   (r_vec),
      .o_sat (w_sat[c])
    );
  end

  assign w_f      = &w_sat;
  assign w_last   = (r_vec == {N_IN{1'b1}});
  assign w_go     = (r_state == ST_IDLE) && start;
  assign w_cfg_ok = cfg_we && (r_state != ST_SWEEP);

`ifdef POS_SWEEP_STEP_EN
  assign w_adv = (r_state == ST_SWEEP) && step;
`else
  assign w_adv = (r_state == ST_SWEEP);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nxt;
  end

  // Next-state logic
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_nxt = ST_SWEEP;
      ST_SWEEP: if (w_adv && w_last) w_nxt = ST_DONE;
      ST_DONE:  w_nxt = ST_IDLE;
      default:  w_nxt = ST_IDLE;
    endcase
  end

  // Clause RAM. Matching against each legal slot index means an
  // out-of-range cfg_idx simply selects nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos <= '0;
      r_neg <= '0;
    end else if (w_cfg_ok) begin
      for (int c = 0; c < N_CLAUSE; c++) begin
        if (cfg_idx == IDX_W'(c)) begin
          r_pos[c] <= cfg_pos;
          r_neg[c] <= cfg_neg;
        end
      end
    end
  end

  // Sweep datapath: cleared on start, updated on each advancing SWEEP cycle,
  // otherwise held so results stay readable in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec  <= '0;
      r_f    <= 1'b0;
      r_ones <= '0;
      r_tt   <= '0;
    end else if (w_go) begin
      r_vec  <= '0;
      r_ones <= '0;
      r_tt   <= '0;
    end else if (w_adv) begin
      r_tt[r_vec] <= w_f;
      r_f         <= w_f;
      r_ones      <= r_ones + (N_IN+1)'(w_f);
      r_vec       <= r_vec + N_IN'(1);
    end
  end

  assign busy     = (r_state == ST_SWEEP);
  assign done     = (r_state == ST_DONE);
  assign vec      = r_vec;
  assign f        = r_f;
  assign ones_cnt = r_ones;
  assign tt       = r_tt;

endmodule

// File: tb/tb_pos_sweep_eval.sv
// Directed bench for pos_sweep_eval: a table of clause sets with hand-computed
// truth tables, plus sequences for mid-sweep start/cfg, async reset mid-sweep,
// a small N_IN=3 instance, and (with POS_SWEEP_STEP_EN) stepped sweeping.
module tb_pos_sweep_eval;

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [4:0]  cfg_pos;
  logic [4:0]  cfg_neg;
  logic        start;
  logic        step;
  logic        busy;
  logic        done;
  logic [4:0]  vec;
  logic        f;
  logic [5:0]  ones_cnt;
  logic [31:0] tt;

  // small instance: N_IN=3, N_CLAUSE=1
  logic        cfg_we3;
  logic [0:0]  cfg_idx3;
  logic [2:0]  cfg_pos3;
  logic [2:0]  cfg_neg3;
  logic        start3;
  logic        step3;
  logic        busy3;
  logic        done3;
  logic [2:0]  vec3;
  logic        f3;
  logic [3:0]  ones3;
  logic [7:0]  tt3;

  int n_chk = 0;
  int n_err = 0;

  pos_sweep_eval u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_pos(cfg_pos), .cfg_neg(cfg_neg), .start(start),
`ifdef POS_SWEEP_STEP_EN
    .step(step),
`endif
    .busy(busy), .done(done), .vec(vec), .f(f), .ones_cnt(ones_cnt), .tt(tt)
  );

  pos_sweep_eval #(.N_IN(3), .N_CLAUSE(1)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we3), .cfg_idx(cfg_idx3),
    .cfg_pos(cfg_pos3), .cfg_neg(cfg_neg3), .start(start3),
`ifdef POS_SWEEP_STEP_EN
    .step(step3),
`endif
    .busy(busy3), .done(done3), .vec(vec3), .f(f3), .ones_cnt(ones3), .tt(tt3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string      name;
    logic [4:0] p0, n0, p1, n1, p2, n2;
    logic [5:0] ones;
    logic [31:0] tt;
    logic       f;
  } vec_t;

  vec_t tbl[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic cfg(input logic [1:0] idx, input logic [4:0] p, input logic [4:0] n);
    cfg_idx = idx; cfg_pos = p; cfg_neg = n; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  // Returns the cycle index (start edge = cycle 0) in which done is seen.
  task automatic run_sweep(output int lat);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  function automatic logic model_f(input int k);
    logic a, b, c, d, e;
    a = k[0]; b = k[1]; c = k[2]; d = k[3]; e = k[4];
    return (a | ~b | c) & (~a | d) & (b | ~c | ~e);
  endfunction

  task automatic load_ref_fn();
    cfg(2'd0, 5'b00101, 5'b00010);
    cfg(2'd1, 5'b01000, 5'b00001);
    cfg(2'd2, 5'b00010, 5'b10100);
  endtask

  initial begin
    int lat;
    logic [31:0] mtt;
    logic done_seen;

    tbl[0] = '{"empty",   5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 6'd32, 32'hFFFF_FFFF, 1'b1};
    tbl[1] = '{"ref_fn",  5'b00101, 5'b00010, 5'b01000, 5'b00001, 5'b00010, 5'b10100,
               6'd17, 32'hCB41_FB51, 1'b1};
    tbl[2] = '{"a_only",  5'b00001, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 6'd16, 32'hAAAA_AAAA, 1'b1};
    tbl[3] = '{"taut",    5'b00001, 5'b00001, 5'h00, 5'h00, 5'h00, 5'h00, 6'd32, 32'hFFFF_FFFF, 1'b1};
    tbl[4] = '{"contra",  5'b00001, 5'h00, 5'h00, 5'b00001, 5'h00, 5'h00, 6'd0, 32'h0, 1'b0};
    tbl[5] = '{"or_all",  5'b11111, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 6'd31, 32'hFFFF_FFFE, 1'b1};

    mtt = '0;
    for (int k = 0; k < 32; k++) mtt[k] = model_f(k);

    rst_n = 1'b0; cfg_we = 0; cfg_idx = 0; cfg_pos = 0; cfg_neg = 0; start = 0; step = 1'b1;
    cfg_we3 = 0; cfg_idx3 = 0; cfg_pos3 = 0; cfg_neg3 = 0; start3 = 0; step3 = 1'b1;
    tick(); tick();

    // reset state
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_vec",  vec, 0);
    chk("rst_f",    f, 0);
    chk("rst_ones", ones_cnt, 0);
    chk("rst_tt",   tt, 0);
    rst_n = 1'b1;
    tick();

    // table-driven sweeps
    for (int i = 0; i < 6; i++) begin
      cfg(2'd0, tbl[i].p0, tbl[i].n0);
      cfg(2'd1, tbl[i].p1, tbl[i].n1);
      cfg(2'd2, tbl[i].p2, tbl[i].n2);
      run_sweep(lat);
      chk({tbl[i].name, "_lat"},  lat, 33);
      chk({tbl[i].name, "_busy"}, busy, 0);
      chk({tbl[i].name, "_ones"}, ones_cnt, tbl[i].ones);
      chk({tbl[i].name, "_tt"},   tt, tbl[i].tt);
      chk({tbl[i].name, "_f"},    f, tbl[i].f);
      tick();
    end

    // results hold in IDLE
    repeat (4) tick();
    chk("idle_hold_tt", tt, 32'hFFFF_FFFE);
    chk("idle_hold_ones", ones_cnt, 31);

    // start + cfg_we pulsed at cycle 10 of a sweep are ignored
    load_ref_fn();
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 200) begin
      if (lat == 10) begin
        chk("mid_vec_c10", vec, 9);
        chk("mid_busy_c10", busy, 1);
        start = 1'b1; cfg_we = 1'b1; cfg_idx = 2'd0; cfg_pos = 5'h00; cfg_neg = 5'h00;
      end else begin
        start = 1'b0; cfg_we = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0; cfg_we = 1'b0;
    chk("mid_lat", lat, 33);
    chk("mid_ones", ones_cnt, 17);
    chk("mid_tt0", tt[0], 1);
    chk("mid_tt1", tt[1], 0);
    chk("mid_tt_model", tt, mtt);

    // start during the DONE cycle is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_start_busy", busy, 0);
    tick();
    chk("done_start_idle", busy, 0);

    // async reset at cycle 15 of a sweep
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (lat < 15) begin tick(); lat++; end
    chk("pre_rst_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_vec",  vec, 0);
    chk("arst_f",    f, 0);
    chk("arst_ones", ones_cnt, 0);
    chk("arst_tt",   tt, 0);
    done_seen = 1'b0;
    tick(); done_seen |= done;
    rst_n = 1'b1;
    repeat (3) begin tick(); done_seen |= done; end
    chk("arst_no_done", done_seen, 0);

    // clause RAM was cleared; an out-of-range index write is dropped
    cfg(2'd3, 5'b00001, 5'b00000);
    run_sweep(lat);
    chk("clr_lat", lat, 33);
    chk("clr_tt", tt, 32'hFFFF_FFFF);
    tick();

    load_ref_fn();
    run_sweep(lat);
    chk("post_rst_lat", lat, 33);
    chk("post_rst_ones", ones_cnt, 17);
    chk("post_rst_tt", tt, 32'hCB41_FB51);
    tick();

    // N_IN=3, single clause x0|x1|x2
    chk("n3_rst_tt", tt3, 0);
    cfg_idx3 = 1'b0; cfg_pos3 = 3'b111; cfg_neg3 = 3'b000; cfg_we3 = 1'b1;
    tick();
    cfg_we3 = 1'b0;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    lat = 1;
    while (!done3 && lat < 200) begin tick(); lat++; end
    chk("n3_lat", lat, 9);
    chk("n3_ones", ones3, 7);
    chk("n3_tt", tt3, 8'hFE);
    tick();

`ifdef POS_SWEEP_STEP_EN
    // stepped sweep: step high every 3rd cycle
    begin
      int steps;
      logic last_step;
      steps = 0; last_step = 1'b0;
      step = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      lat = 1;
      while (!done && lat < 400) begin
        chk("step_busy", busy, 1);
        chk("step_vec", vec, steps % 32);
        step = (lat % 3 == 0);
        last_step = step;
        if (step) steps++;
        tick();
        lat++;
      end
      step = 1'b1;
      chk("step_done_seen", done, 1);
      chk("step_count", steps, 32);
      chk("step_last", last_step, 1);
      chk("step_ones", ones_cnt, 17);
      chk("step_tt", tt, 32'hCB41_FB51);
      tick();
    end
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
